// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: show-ahead FIFO of (address, instruction) pairs
// between fetch and decode, with pipeline hold and redirect flush.
module ifetch_buf #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  input  logic [XLEN-1:0]          in_addr_i,
  input  logic [XLEN-1:0]          in_inst_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  output logic [XLEN-1:0]          out_addr_o,
  output logic [XLEN-1:0]          out_inst_o,
  input  logic                     out_ready_i,
  input  logic                     hold_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_addr_mem [DEPTH];
  logic [XLEN-1:0] r_inst_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic w_push;
  logic w_pop;

  // Full blocks pushes even when a pop frees a slot in the same cycle.
  assign in_ready_o  = (r_count < CW'(DEPTH));
  assign out_valid_o = (r_count != '0);
  assign w_push      = in_valid_i & in_ready_o & ~flush_i;
  assign w_pop       = out_valid_o & out_ready_i & ~hold_i & ~flush_i;

  assign out_addr_o  = out_valid_o ? r_addr_mem[r_rptr] : '0;
  assign out_inst_o  = out_valid_o ? r_inst_mem[r_rptr] : NOP_INST;
  assign count_o     = r_count;

  // Storage holds no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= in_addr_i;
      r_inst_mem[r_wptr] <= in_inst_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_buf.sv
// Self-checking bench for ifetch_buf: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_ifetch_buf;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
  } entry_t;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid_i;
  logic [XLEN-1:0]       in_addr_i;
  logic [XLEN-1:0]       in_inst_i;
  logic                  in_ready_o;
  logic                  out_valid_o;
  logic [XLEN-1:0]       out_addr_o;
  logic [XLEN-1:0]       out_inst_o;
  logic                  out_ready_i;
  logic                  hold_i;
  logic                  flush_i;
  logic [$clog2(DEPTH):0] count_o;

  entry_t model[$];
  int testsRun    = 0;
  int testsFailed = 0;

  ifetch_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_addr_i   (in_addr_i),
    .in_inst_i   (in_inst_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_addr_o  (out_addr_o),
    .out_inst_o  (out_inst_o),
    .out_ready_i (out_ready_i),
    .hold_i      (hold_i),
    .flush_i     (flush_i),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic compareModel();
    int sz = model.size();
    checkOutput("count", 64'(count_o), 64'(sz));
    checkOutput("in_ready", 64'(in_ready_o), 64'(sz < DEPTH));
    checkOutput("out_valid", 64'(out_valid_o), 64'(sz != 0));
    if (sz != 0) begin
      checkOutput("head_addr", 64'(out_addr_o), 64'(model[0].addr));
      checkOutput("head_inst", 64'(out_inst_o), 64'(model[0].inst));
    end else begin
      checkOutput("empty_addr", 64'(out_addr_o), 64'd0);
      checkOutput("empty_inst", 64'(out_inst_o), 64'(NOP));
    end
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks.
  task automatic applyStimulus(input logic v, input logic [XLEN-1:0] a,
                               input logic rdy, input logic hld, input logic fl);
    int     sz;
    entry_t e;
    bit     doPop;
    bit     doPush;
    in_valid_i  = v;
    in_addr_i   = a;
    in_inst_i   = a ^ 32'hA5C3_0F00;
    out_ready_i = rdy;
    hold_i      = hld;
    flush_i     = fl;
    e.addr = in_addr_i;
    e.inst = in_inst_i;
    @(posedge clk);
    sz = model.size();
    if (fl) begin
      model.delete();
    end else begin
      doPop  = (sz > 0) && rdy && !hld;
      doPush = v && (sz < DEPTH);
      if (doPop)  void'(model.pop_front());
      if (doPush) model.push_back(e);
    end
    #1;
    compareModel();
  endtask

  initial begin
    logic [XLEN-1:0] drainHeads [4];
    drainHeads = '{32'h08, 32'h0C, 32'h10, 32'h14};
    rst_n = 1'b0; in_valid_i = 1'b0; in_addr_i = '0; in_inst_i = '0;
    out_ready_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
    #12;
    checkOutput("rst_count", 64'(count_o), 64'd0);
    checkOutput("rst_ready", 64'(in_ready_o), 64'd1);
    checkOutput("rst_inst", 64'(out_inst_o), 64'(NOP));
    compareModel();
    rst_n = 1'b1;

    // Fill to full without consuming.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, XLEN'(i * 4), 1'b0, 1'b0, 1'b0);
    checkOutput("fill_count", 64'(count_o), 64'd4);
    checkOutput("fill_ready", 64'(in_ready_o), 64'd0);
    checkOutput("fill_head", 64'(out_addr_o), 64'h00);

    // Pop two, push two across the wrap, then drain.
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_head", 64'(out_addr_o), 64'(drainHeads[i]));
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("drain_count", 64'(count_o), 64'd0);
    checkOutput("drain_inst", 64'(out_inst_o), 64'h13);

    // Full with simultaneous push and pop: only the pop happens.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, XLEN'(32'h20 + i * 4), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h99, 1'b1, 1'b0, 1'b0);
    checkOutput("full_pp_count", 64'(count_o), 64'd3);

    // Flush wins over same-cycle push and pop.
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_count", 64'(count_o), 64'd0);
    checkOutput("flush_valid", 64'(out_valid_o), 64'd0);

    // Hold freezes the read side while pushes continue up to full.
    applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h54, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, XLEN'(32'h58 + i * 4), 1'b1, 1'b1, 1'b0);
    checkOutput("hold_head", 64'(out_addr_o), 64'h50);
    checkOutput("hold_count", 64'(count_o), 64'd4);

    // Asynchronous reset between edges.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_areset", 64'(count_o), 64'd3);
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model.delete();
    checkOutput("areset_count", 64'(count_o), 64'd0);
    checkOutput("areset_valid", 64'(out_valid_o), 64'd0);
    compareModel();
    #3 rst_n = 1'b1;
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    checkOutput("first_push", 64'(count_o), 64'd1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), $urandom(),
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) < 3),
                    ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ifetch_buf.md
IFETCH_BUF -- requirements
Module: ifetch_buf

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of instruction and address fields.
REQ-002 Parameter DEPTH, default 4, SHALL set the entry count; legal values are powers of two, 2..64.
REQ-003 Parameter NOP_INST, default 32'h0000_0013, SHALL set the instruction presented when the buffer is empty.
REQ-004 There SHALL be one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid_i  input  1  fetch side offers an entry.
REQ-008 in_addr_i  input  XLEN  instruction address of the offered entry.
REQ-009 in_inst_i  input  XLEN  instruction word of the offered entry.
REQ-010 in_ready_o  output  1  buffer accepts an entry this cycle.
REQ-011 out_valid_o  output  1  head entry is valid.
REQ-012 out_addr_o  output  XLEN  head entry address.
REQ-013 out_inst_o  output  XLEN  head entry instruction.
REQ-014 out_ready_i  input  1  decode side consumes the head this cycle.
REQ-015 hold_i  input  1  pipeline hold from ctrl; blocks consumption.
REQ-016 flush_i  input  1  jump/redirect from ctrl; discards all entries.
REQ-017 count_o  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-018 Push SHALL occur when in_valid_i & in_ready_o & !flush_i; entry written at the write pointer.
REQ-019 in_ready_o SHALL equal (count_o < DEPTH); no pass-through when full, even if a pop occurs the same cycle.
REQ-020 Pop SHALL occur when out_valid_o & out_ready_i & !hold_i & !flush_i; read pointer advances.
REQ-021 Head SHALL be show-ahead: out_addr_o/out_inst_o reflect the entry at the read pointer combinationally from storage, zero extra latency.
REQ-022 A pushed entry SHALL appear at the head no earlier than the cycle after the push (one-cycle fill latency into an empty buffer).
REQ-023 out_valid_o SHALL equal (count_o != 0).
REQ-024 When out_valid_o=0, out_inst_o SHALL be NOP_INST and out_addr_o SHALL be 0.
REQ-025 Simultaneous push and pop SHALL leave count_o unchanged and advance both pointers.
REQ-026 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without gaps.
REQ-027 count_o SHALL increment on push-only, decrement on pop-only, never exceed DEPTH nor underflow 0.
REQ-028 flush_i=1 SHALL, on the next edge, set both pointers and count_o to 0; same-cycle push and pop are suppressed.
REQ-029 flush_i SHALL take priority over hold_i; hold_i with flush_i=0 SHALL freeze the read side only (pushes continue while not full).
REQ-030 Entry order SHALL be strictly FIFO; no entry duplicated or dropped except by flush.
REQ-031 Storage contents need no reset; only pointers and count are reset.

Reset
REQ-032 While rst_n=0: count_o=0, out_valid_o=0, in_ready_o=1, out_inst_o=NOP_INST, out_addr_o=0, pointers=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately, independent of clk.
REQ-034 After rst_n deassertion, the first push SHALL be accepted on the first rising edge.

Verification
REQ-035 Fill: DEPTH=4, push addr 0x00,0x04,0x08,0x0C with out_ready_i=0 -> count_o=4, in_ready_o=0, head addr 0x00.
REQ-036 Drain with wrap: from full, pop 2, push 0x10,0x14, pop 4 -> heads in order 0x08,0x0C,0x10,0x14; count_o=0, out_inst_o=0x00000013.
REQ-037 Full with push+pop: count_o=4, in_valid_i=1, out_ready_i=1 -> pop only, count_o=3, offered entry not taken.
REQ-038 Flush: count_o=3, flush_i=1 with in_valid_i=1 and out_ready_i=1 -> next cycle count_o=0, out_valid_o=0, no entry stored.
REQ-039 Hold: count_o=2, hold_i=1, out_ready_i=1, in_valid_i=1 for 3 cycles -> head unchanged, count_o saturates at 4.
REQ-040 Async reset: count_o=3, drop rst_n between edges -> count_o=0 and out_valid_o=0 before next edge.
